repairclk_pattern_detector: RTL and testbench

- Receive-side clock-track detector for the MBINIT.REPAIRCLK step.
- Samples the three received clock lanes (RCKP, RCKN, RTRK) while the REPAIRCLK partner logic enables detection, and checks each lane for the clock-repair pattern.
- Drives i_CLK_Track_done and the 3-bit i_Clock_track_result_logged_COMB, which the REPAIRCLK partner reports back to the link partner over sideband.

---
 rtl/repairclk_pattern_detector_pkg.sv | 31 +++
 rtl/repairclk_pattern_detector_lane.sv | 87 ++++++++
 rtl/repairclk_pattern_detector.sv | 99 +++++++++
 tb/tb_repairclk_pattern_detector.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/repairclk_pattern_detector_pkg.sv
// Shared constants and types for the MBINIT.REPAIRCLK receive-side clock-track detector.
package repairclk_pattern_detector_pkg;

    localparam int REPAIRCLK_TOGGLE_UI     = 16;
    localparam int REPAIRCLK_LOW_UI        = 8;
    localparam int REPAIRCLK_MIN_ITER      = 16;
    localparam int REPAIRCLK_WINDOW_CYCLES = 3200;
    localparam int REPAIRCLK_CNT_W         = 12;

    localparam int LANE_RCKP = 0;
    localparam int LANE_RCKN = 1;
    localparam int LANE_RTRK = 2;
    localparam int NUM_LANES = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DETECT = 2'd1,
        ST_DONE   = 2'd2
    } top_state_t;

    typedef enum logic {
        LANE_HUNT  = 1'b0,
        LANE_TRACK = 1'b1
    } lane_state_t;

    // Toggle section is 1010... starting at idx 0; the low tail is all zeros.
    function automatic logic expected_bit(input logic [4:0] idx, input logic [4:0] toggle_ui);
        return (idx < toggle_ui) ? ~idx[0] : 1'b0;
    endfunction

endpackage

// File: rtl/repairclk_pattern_detector_lane.sv
// Per-lane HUNT/TRACK tracker: counts consecutive clean iterations and latches a sticky pass.
module repairclk_lane_detector
    import repairclk_pattern_detector_pkg::*;
#(
    parameter int TOGGLE_UI = REPAIRCLK_TOGGLE_UI,
    parameter int LOW_UI    = REPAIRCLK_LOW_UI,
    parameter int MIN_ITER  = REPAIRCLK_MIN_ITER
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_sample,
    output logic o_pass
);

    localparam logic [4:0] C_LAST   = 5'(TOGGLE_UI + LOW_UI - 1);
    localparam logic [4:0] C_TOGGLE = 5'(TOGGLE_UI);
    localparam logic [4:0] C_MIN    = 5'(MIN_ITER);

    lane_state_t r_state;
    logic [4:0]  r_idx;
    logic [4:0]  r_consec;
    logic        r_pass;

    logic       w_expected;
    logic       w_iter_done;
    logic [4:0] w_consec_inc;

    assign w_expected   = expected_bit(r_idx, C_TOGGLE);
    assign w_iter_done  = i_enable && (r_state == LANE_TRACK) && (i_sample == w_expected)
                          && (r_idx == C_LAST);
    assign w_consec_inc = (r_consec >= C_MIN) ? C_MIN : r_consec + 5'd1;

    // Look-ahead so an iteration finishing on the window-close cycle still counts.
    assign o_pass = r_pass | (w_iter_done && (w_consec_inc == C_MIN));

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= LANE_HUNT;
            r_idx    <= 5'd0;
            r_consec <= 5'd0;
            r_pass   <= 1'b0;
        end else if (i_clear) begin
            r_state  <= LANE_HUNT;
            r_idx    <= 5'd0;
            r_consec <= 5'd0;
            r_pass   <= 1'b0;
        end else if (i_enable) begin
            case (r_state)
                LANE_HUNT: begin
                    if (i_sample) begin
                        r_state <= LANE_TRACK;
                        r_idx   <= 5'd1;
                    end
                end
                LANE_TRACK: begin
                    if (i_sample == w_expected) begin
                        if (r_idx == C_LAST) begin
                            r_idx    <= 5'd0;
                            r_consec <= w_consec_inc;
                            if (w_consec_inc == C_MIN) begin
                                r_pass <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 5'd1;
                        end
                    end else begin
                        r_consec <= 5'd0;
                        // A mismatching 1 may be the start of a fresh iteration.
                        if (i_sample) begin
                            r_idx <= 5'd1;
                        end else begin
                            r_state <= LANE_HUNT;
                            r_idx   <= 5'd0;
                        end
                    end
                end
                default: begin
                    r_state <= LANE_HUNT;
                    r_idx   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/repairclk_pattern_detector.sv
// REPAIRCLK clock-track detector top: window FSM plus one pattern tracker per received clock lane.
module repairclk_pattern_detector
    import repairclk_pattern_detector_pkg::*;
#(
    parameter int TOGGLE_UI     = REPAIRCLK_TOGGLE_UI,
    parameter int LOW_UI        = REPAIRCLK_LOW_UI,
    parameter int MIN_ITER      = REPAIRCLK_MIN_ITER,
    parameter int WINDOW_CYCLES = REPAIRCLK_WINDOW_CYCLES,
    parameter int CNT_W         = REPAIRCLK_CNT_W
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_detect_en,
    input  logic       i_rckp,
    input  logic       i_rckn,
    input  logic       i_rtrk,
    output logic       o_CLK_Track_done,
    output logic [2:0] o_Clock_track_result_logged
);

    top_state_t             r_state;
    logic [CNT_W-1:0]       r_win_cnt;
    logic                   r_done;
    logic [NUM_LANES-1:0]   r_result;

    logic [NUM_LANES-1:0]   w_lane_sample;
    logic [NUM_LANES-1:0]   w_lane_pass;
    logic                   w_lane_clear;
    logic                   w_lane_enable;
    logic                   w_window_end;

    assign w_lane_sample[LANE_RCKP] = i_rckp;
    assign w_lane_sample[LANE_RCKN] = i_rckn;
    assign w_lane_sample[LANE_RTRK] = i_rtrk;

    assign w_lane_clear  = (r_state == ST_IDLE) && i_detect_en;
    assign w_lane_enable = (r_state == ST_DETECT);
    assign w_window_end  = (r_win_cnt == CNT_W'(WINDOW_CYCLES - 1));

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            repairclk_lane_detector #(
                .TOGGLE_UI (TOGGLE_UI),
                .LOW_UI    (LOW_UI),
                .MIN_ITER  (MIN_ITER)
            ) u_lane (
                .CLK      (CLK),
                .rst_n    (rst_n),
                .i_clear  (w_lane_clear),
                .i_enable (w_lane_enable),
                .i_sample (w_lane_sample[gi]),
                .o_pass   (w_lane_pass[gi])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_win_cnt <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_detect_en) begin
                        r_state   <= ST_DETECT;
                        r_win_cnt <= '0;
                        r_result  <= '0;
                    end
                end
                ST_DETECT: begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                    if (w_window_end || !i_detect_en) begin
                        r_state  <= ST_DONE;
                        r_result <= w_lane_pass;
                        r_done   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result stays latched after done drops, until the next detection run.
                    if (!i_detect_en) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_CLK_Track_done            = r_done;
    assign o_Clock_track_result_logged = r_result;

endmodule

// File: tb/tb_repairclk_pattern_detector.sv
// Directed bench for repairclk_pattern_detector: per-lane stimulus generators and fixed expected results.
module tb_repairclk_pattern_detector;

    localparam int WIN     = 3200;
    localparam int M_CLEAN = 0;
    localparam int M_ZERO  = 1;
    localparam int M_ONE   = 2;
    localparam int M_ERR   = 3;
    localparam int M_STRAY = 4;

    logic       CLK;
    logic       rst_n;
    logic       en;
    logic       rckp;
    logic       rckn;
    logic       rtrk;
    logic       done;
    logic [2:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int lane_mode [3];
    int lane_arg  [3];

    repairclk_pattern_detector dut (
        .CLK                         (CLK),
        .rst_n                       (rst_n),
        .i_detect_en                 (en),
        .i_rckp                      (rckp),
        .i_rckn                      (rckn),
        .i_rtrk                      (rtrk),
        .o_CLK_Track_done            (done),
        .o_Clock_track_result_logged (result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference clock-repair pattern: 8 x "10" then 8 zeros, 24 UI per iteration.
    function automatic logic pat(input int p);
        int pos;
        pos = p % 24;
        return (pos < 16) && (pos % 2 == 0);
    endfunction

    function automatic logic lane_bit(input int mode, input int arg, input int t);
        int iter;
        iter = t / 24;
        case (mode)
            M_CLEAN: return (t < arg) ? 1'b0 : pat(t - arg);
            M_ZERO:  return 1'b0;
            M_ONE:   return 1'b1;
            M_ERR: begin
                // 15 clean iterations, iteration 15 corrupted at pos 2, then arg clean, then silence
                if (iter == 15 && (t % 24) == 2) return 1'b0;
                if (iter > 15 + arg) return 1'b0;
                return pat(t);
            end
            M_STRAY: begin
                if (t < 3) return 1'b0;
                if (t < 5) return 1'b1;
                return pat(t - 5);
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_modes(input int m0, input int a0, input int m1, input int a1,
                             input int m2, input int a2);
        lane_mode[0] = m0; lane_arg[0] = a0;
        lane_mode[1] = m1; lane_arg[1] = a1;
        lane_mode[2] = m2; lane_arg[2] = a2;
    endtask

    task automatic drive_lanes(input int t);
        rckp = lane_bit(lane_mode[0], lane_arg[0], t);
        rckn = lane_bit(lane_mode[1], lane_arg[1], t);
        rtrk = lane_bit(lane_mode[2], lane_arg[2], t);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Enters DETECT, streams samples until window expiry or abort_t, checks done/result.
    task automatic run_window(input string tag, input int abort_t, input logic [2:0] exp_res);
        int last;
        last = (abort_t >= 0) ? abort_t : WIN - 1;
        en = 1'b1; rckp = 1'b0; rckn = 1'b0; rtrk = 1'b0;
        tick();
        n_checks++;
        if (result !== 3'b000) $display("FAIL %s_entry_clear: result=%b expected 000", tag, result);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL %s_entry_done: done=%b expected 0", tag, done);
        else n_pass++;
        for (int t = 0; t <= last; t++) begin
            drive_lanes(t);
            if (t == abort_t) en = 1'b0;
            tick();
            if (t == last - 1) begin
                n_checks++;
                if (done !== 1'b0) $display("FAIL %s_done_early: done=%b expected 0 at t=%0d", tag, done, t);
                else n_pass++;
            end
        end
        n_checks++;
        if (done !== 1'b1) $display("FAIL %s_done: done=%b expected 1", tag, done);
        else n_pass++;
        n_checks++;
        if (result !== exp_res) $display("FAIL %s_result: result=%b expected %b", tag, result, exp_res);
        else n_pass++;
        $display("%s: done=%b result=%b (expected %b)", tag, done, result, exp_res);
    endtask

    task automatic finish_window(input string tag, input logic [2:0] exp_res);
        en = 1'b0; rckp = 1'b0; rckn = 1'b0; rtrk = 1'b0;
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL %s_done_drop: done=%b expected 0", tag, done);
        else n_pass++;
        n_checks++;
        if (result !== exp_res) $display("FAIL %s_retained: result=%b expected %b", tag, result, exp_res);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset_done: done=%b expected 0", done);
        else n_pass++;
        n_checks++;
        if (result !== 3'b000) $display("FAIL reset_result: result=%b expected 000", result);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (done !== 1'b0) $display("FAIL idle_done: done=%b expected 0", done);
        else n_pass++;
        $display("reset: done=%b result=%b", done, result);
    endtask

    task automatic test_all_clean();
        set_modes(M_CLEAN, 0, M_CLEAN, 0, M_CLEAN, 0);
        run_window("clean", -1, 3'b111);
        repeat (3) tick();
        n_checks++;
        if (done !== 1'b1) $display("FAIL clean_hold: done=%b expected 1 while en high", done);
        else n_pass++;
        finish_window("clean", 3'b111);
    endtask

    task automatic test_rckn_stuck();
        set_modes(M_CLEAN, 0, M_ZERO, 0, M_CLEAN, 0);
        run_window("rckn_stuck0", -1, 3'b101);
        finish_window("rckn_stuck0", 3'b101);
    endtask

    task automatic test_rtrk_error();
        set_modes(M_CLEAN, 0, M_CLEAN, 0, M_ERR, 15);
        run_window("rtrk_err_15", -1, 3'b011);
        finish_window("rtrk_err_15", 3'b011);
        set_modes(M_CLEAN, 0, M_CLEAN, 0, M_ERR, 16);
        run_window("rtrk_err_16", -1, 3'b111);
        finish_window("rtrk_err_16", 3'b111);
    endtask

    task automatic test_stray();
        set_modes(M_STRAY, 0, M_STRAY, 0, M_STRAY, 0);
        run_window("stray_realign", -1, 3'b111);
        finish_window("stray_realign", 3'b111);
    endtask

    // 16th iteration lands on the last window cycle (pass) vs one cycle beyond (fail).
    task automatic test_window_edge();
        set_modes(M_CLEAN, WIN - 384, M_CLEAN, WIN - 383, M_ONE, 0);
        run_window("window_edge", -1, 3'b001);
        finish_window("window_edge", 3'b001);
    endtask

    task automatic test_abort();
        set_modes(M_CLEAN, 0, M_CLEAN, 0, M_CLEAN, 0);
        run_window("abort_10iter", 239, 3'b000);
        finish_window("abort_10iter", 3'b000);
    endtask

    task automatic test_reset_mid();
        set_modes(M_CLEAN, 0, M_CLEAN, 0, M_CLEAN, 0);
        en = 1'b1;
        tick();
        for (int t = 0; t < 600; t++) begin
            drive_lanes(t);
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL rst_mid_detect_done: done=%b expected 0", done);
        else n_pass++;
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_window("post_reset", -1, 3'b111);
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0) $display("FAIL rst_in_done_done: done=%b expected 0", done);
        else n_pass++;
        n_checks++;
        if (result !== 3'b000) $display("FAIL rst_in_done_result: result=%b expected 000", result);
        else n_pass++;
        $display("reset_in_done: done=%b result=%b", done, result);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        rckp  = 1'b0;
        rckn  = 1'b0;
        rtrk  = 1'b0;
        set_modes(M_ZERO, 0, M_ZERO, 0, M_ZERO, 0);
        repeat (3) tick();
        test_reset();
        test_all_clean();
        test_rckn_stuck();
        test_rtrk_error();
        test_stray();
        test_window_edge();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
